attitude_classifier: RTL and testbench

ATTITUDE_CLASSIFIER -- requirements
Module: attitude_classifier

---
 rtl/attitude_classifier_pkg.sv | 36 +++
 rtl/attitude_classifier_axis_hysteresis.sv | 102 ++++++++++
 rtl/attitude_classifier.sv | 78 +++++++
 tb/tb_attitude_classifier.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/attitude_classifier_pkg.sv
// Shared types and constants for the roll/pitch attitude classifier.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the per-axis state encoding, the o_Attitude bit positions and the
// reset code, plus the encoder that maps two axis states onto o_Attitude.
package attitude_classifier_pkg;

  typedef enum logic [1:0] {
    AXIS_ZERO = 2'b00,
    AXIS_POS  = 2'b01,
    AXIS_NEG  = 2'b10
  } axis_state_t;

  localparam int ATT_ROLL_SGN   = 0;
  localparam int ATT_PITCH_SGN  = 1;
  localparam int ATT_ROLL_ZERO  = 2;
  localparam int ATT_PITCH_ZERO = 3;

  // Both axes in ZERO.
  localparam logic [3:0] ATT_RESET = 4'b1100;

  // sgn bit is set only for NEG, isZero bit only for ZERO, so every
  // distinct pair of axis states gives a distinct code.
  function automatic logic [3:0] encode_attitude(input axis_state_t roll,
                                                 input axis_state_t pitch);
    logic [3:0] att;
    att                 = 4'b0000;
    att[ATT_ROLL_SGN]   = (roll  == AXIS_NEG);
    att[ATT_PITCH_SGN]  = (pitch == AXIS_NEG);
    att[ATT_ROLL_ZERO]  = (roll  == AXIS_ZERO);
    att[ATT_PITCH_ZERO] = (pitch == AXIS_ZERO);
    return att;
  endfunction

endpackage

// File: rtl/attitude_classifier_axis_hysteresis.sv
// Per-axis ZERO/POS/NEG classifier with hysteresis and N-sample confirmation.
// Latency: state updates on the edge that accepts the confirming sample.
// Backpressure: none; a sample is consumed on every cycle valid is high.
//
// Ports: clk, rst (sync active-high), valid, sample (signed DATA_W),
//        state (registered axis state), state_next (value state takes next edge).
module axis_hysteresis
  import attitude_classifier_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ENTER_TH  = 256,
  parameter int EXIT_TH   = 128,
  parameter int CONFIRM_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  output axis_state_t       state,
  output axis_state_t       state_next
);

  // One extra bit keeps -ENTER_TH and the most-negative sample representable.
  localparam logic signed [DATA_W:0] ENTER_POS = (DATA_W + 1)'(ENTER_TH);
  localparam logic signed [DATA_W:0] ENTER_NEG = (DATA_W + 1)'(-ENTER_TH);
  localparam logic signed [DATA_W:0] EXIT_POS  = (DATA_W + 1)'(EXIT_TH);
  localparam logic signed [DATA_W:0] EXIT_NEG  = (DATA_W + 1)'(-EXIT_TH);
  localparam logic [3:0]             CONFIRM   = 4'(CONFIRM_N);

  axis_state_t             pending;
  axis_state_t             pending_next;
  axis_state_t             cand;
  logic [3:0]              cnt;
  logic [3:0]              cnt_next;
  logic [3:0]              cnt_inc;
  logic signed [DATA_W:0]  sx;

  assign sx = $signed({sample[DATA_W-1], sample});

  // Leaving ZERO needs |x| > ENTER_TH; returning needs |x| < EXIT_TH.
  // A sign flip from POS/NEG needs the full ENTER_TH on the other side.
  always_comb begin
    cand = state;
    case (state)
      AXIS_ZERO: begin
        if (sx > ENTER_POS)      cand = AXIS_POS;
        else if (sx < ENTER_NEG) cand = AXIS_NEG;
        else                     cand = AXIS_ZERO;
      end
      AXIS_POS: begin
        if (sx < ENTER_NEG)      cand = AXIS_NEG;
        else if (sx < EXIT_POS)  cand = AXIS_ZERO;
        else                     cand = AXIS_POS;
      end
      AXIS_NEG: begin
        if (sx > ENTER_POS)      cand = AXIS_POS;
        else if (sx > EXIT_NEG)  cand = AXIS_ZERO;
        else                     cand = AXIS_NEG;
      end
      default:                   cand = AXIS_ZERO;
    endcase
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    cnt_next     = cnt;
    cnt_inc      = 4'd0;
    if (valid) begin
      if (cand == state) begin
        cnt_next = 4'd0;
      end else begin
        if (cand == pending) begin
          cnt_inc = cnt + 4'd1;
        end else begin
          pending_next = cand;
          cnt_inc      = 4'd1;
        end
        // The confirming sample switches state on its own edge.
        if (cnt_inc == CONFIRM) begin
          state_next = cand;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= AXIS_ZERO;
      pending <= AXIS_ZERO;
      cnt     <= 4'd0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      cnt     <= cnt_next;
    end
  end

endmodule

// File: rtl/attitude_classifier.sv
// Roll/pitch attitude classifier driving the seven-segment attitude decoder.
// Latency: o_Attitude changes right after the confirming sample's edge; o_Update
//          is high for exactly the following cycle.
// Backpressure: none; every i_Valid sample is consumed.
//
// Ports: i_Clk, i_Rst (sync active-high), i_Valid, i_Roll/i_Pitch (signed
//        DATA_W), o_Attitude {isZero(pitch), isZero(roll), sgn(pitch), sgn(roll)},
//        o_Update (one-cycle change pulse).
module attitude_classifier
  import attitude_classifier_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ENTER_TH  = 256,
  parameter int EXIT_TH   = 128,
  parameter int CONFIRM_N = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  input  logic [DATA_W-1:0] i_Roll,
  input  logic [DATA_W-1:0] i_Pitch,
  output logic [3:0]        o_Attitude,
  output logic              o_Update
);

  axis_state_t roll_state;
  axis_state_t roll_next;
  axis_state_t pitch_state;
  axis_state_t pitch_next;
  logic [3:0]  att_next;

  axis_hysteresis #(
    .DATA_W    (DATA_W),
    .ENTER_TH  (ENTER_TH),
    .EXIT_TH   (EXIT_TH),
    .CONFIRM_N (CONFIRM_N)
  ) u_roll (
    .clk        (i_Clk),
    .rst        (i_Rst),
    .valid      (i_Valid),
    .sample     (i_Roll),
    .state      (roll_state),
    .state_next (roll_next)
  );

  axis_hysteresis #(
    .DATA_W    (DATA_W),
    .ENTER_TH  (ENTER_TH),
    .EXIT_TH   (EXIT_TH),
    .CONFIRM_N (CONFIRM_N)
  ) u_pitch (
    .clk        (i_Clk),
    .rst        (i_Rst),
    .valid      (i_Valid),
    .sample     (i_Pitch),
    .state      (pitch_state),
    .state_next (pitch_next)
  );

  // Encoding from next-state keeps o_Attitude aligned with the axis registers
  // and lets a simultaneous roll+pitch change produce a single pulse.
  assign att_next = encode_attitude(roll_next, pitch_next);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Attitude <= ATT_RESET;
      o_Update   <= 1'b0;
    end else begin
      o_Attitude <= att_next;
      o_Update   <= (att_next != o_Attitude);
    end
  end

  // Any confirmed axis transition must be visible on o_Attitude.
  a_transition_visible: assert property (@(posedge i_Clk) disable iff (i_Rst)
    ((roll_next != roll_state) || (pitch_next != pitch_state)) |-> (att_next != o_Attitude));

endmodule

// File: tb/tb_attitude_classifier.sv
// Directed self-checking bench for attitude_classifier (ENTER 256, EXIT 128, N 3).
// Latency: n/a.
// Backpressure: n/a.
module tb_attitude_classifier;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_Valid = 1'b0;
  logic [15:0] i_Roll = 16'd0;
  logic [15:0] i_Pitch = 16'd0;
  logic [3:0]  o_Attitude;
  logic        o_Update;

  int tests = 0;
  int failures = 0;

  attitude_classifier #(
    .DATA_W    (16),
    .ENTER_TH  (256),
    .EXIT_TH   (128),
    .CONFIRM_N (3)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Valid    (i_Valid),
    .i_Roll     (i_Roll),
    .i_Pitch    (i_Pitch),
    .o_Attitude (o_Attitude),
    .o_Update   (o_Update)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [3:0] exp_att, input logic exp_upd);
    tests++;
    assert (o_Attitude === exp_att) else begin
      failures++;
      $error("FAIL %s attitude observed=%b expected=%b", tag, o_Attitude, exp_att);
    end
    tests++;
    assert (o_Update === exp_upd) else begin
      failures++;
      $error("FAIL %s update observed=%b expected=%b", tag, o_Update, exp_upd);
    end
  endtask

  task automatic smp(input int r, input int p);
    i_Roll  = 16'(r);
    i_Pitch = 16'(p);
    i_Valid = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    idle();
    idle();
    i_Rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("reset", 4'b1100, 1'b0);

    // Roll enters POS after three samples above ENTER_TH
    smp(300, 0);  check("enter_s1", 4'b1100, 1'b0);
    smp(300, 0);  check("enter_s2", 4'b1100, 1'b0);
    smp(300, 0);  check("enter_s3", 4'b1000, 1'b1);
    idle();       check("enter_idle", 4'b1000, 1'b0);

    // Hysteresis band holds POS, including exactly EXIT_TH
    smp(200, 0);  check("band_200a", 4'b1000, 1'b0);
    smp(200, 0);  check("band_200b", 4'b1000, 1'b0);
    smp(200, 0);  check("band_200c", 4'b1000, 1'b0);
    smp(128, 0);  check("band_128a", 4'b1000, 1'b0);
    smp(128, 0);  check("band_128b", 4'b1000, 1'b0);
    smp(128, 0);  check("band_128c", 4'b1000, 1'b0);
    smp(100, 0);  check("exit_s1", 4'b1000, 1'b0);
    smp(100, 0);  check("exit_s2", 4'b1000, 1'b0);
    smp(100, 0);  check("exit_s3", 4'b1100, 1'b1);
    idle();       check("exit_idle", 4'b1100, 1'b0);

    // Interrupted run: only the final three agreeing samples confirm
    smp(300, 0);  check("run_s1", 4'b1100, 1'b0);
    smp(300, 0);  check("run_s2", 4'b1100, 1'b0);
    smp(-300, 0); check("run_s3", 4'b1100, 1'b0);
    smp(300, 0);  check("run_s4", 4'b1100, 1'b0);
    smp(300, 0);  check("run_s5", 4'b1100, 1'b0);
    smp(300, 0);  check("run_s6", 4'b1000, 1'b1);
    idle();       check("run_idle", 4'b1000, 1'b0);

    // Most-negative roll flips POS->NEG while pitch goes NEG on the same edge
    smp(-32768, -500); check("minneg_s1", 4'b1000, 1'b0);
    smp(-32768, -500); check("minneg_s2", 4'b1000, 1'b0);
    smp(-32768, -500); check("minneg_s3", 4'b0011, 1'b1);
    idle();            check("minneg_idle", 4'b0011, 1'b0);

    // Reset from a non-zero attitude; exactly +/-ENTER_TH stays ZERO
    do_reset();
    check("reset2", 4'b1100, 1'b0);
    smp(256, 256);   check("edge_p1", 4'b1100, 1'b0);
    smp(256, 256);   check("edge_p2", 4'b1100, 1'b0);
    smp(256, 256);   check("edge_p3", 4'b1100, 1'b0);
    smp(-256, -256); check("edge_n1", 4'b1100, 1'b0);
    smp(-256, -256); check("edge_n2", 4'b1100, 1'b0);
    smp(-256, -256); check("edge_n3", 4'b1100, 1'b0);

    // Pitch alone goes POS
    smp(0, 400); smp(0, 400);
    check("pitch_s2", 4'b1100, 1'b0);
    smp(0, 400); check("pitch_s3", 4'b0100, 1'b1);

    // Valid gap does not break a run
    do_reset();
    smp(300, 0); smp(300, 0);
    repeat (5) idle();
    check("gap_hold", 4'b1100, 1'b0);
    smp(300, 0); check("gap_s3", 4'b1000, 1'b1);
    idle();      check("gap_idle", 4'b1000, 1'b0);

    // Reset in the gap discards the partial run; valid during reset is ignored
    do_reset();
    smp(300, 0); smp(300, 0);
    idle();
    i_Rst = 1'b1;
    smp(300, 0);
    smp(300, 0);
    i_Rst = 1'b0;
    idle();
    check("rstgap_hold", 4'b1100, 1'b0);
    smp(300, 0); check("rstgap_s1", 4'b1100, 1'b0);
    smp(300, 0); check("rstgap_s2", 4'b1100, 1'b0);
    smp(300, 0); check("rstgap_s3", 4'b1000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
